// File: rtl/execute_stage_if.sv
// ID/EX operand, writeback-forwarding and EX/MEM result bundle for the execute stage.
// The master drives ID/EX and writeback; the slave (execute stage) drives EX/MEM.
interface execute_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5
);
  logic [WIDTH-1:0] PC_E;
  logic [WIDTH-1:0] imm_data_E;
  logic [WIDTH-1:0] rd1_E;
  logic [WIDTH-1:0] rd2_E;
  logic [REGW-1:0]  rs1_E;
  logic [REGW-1:0]  rs2_E;
  logic [REGW-1:0]  rd_E;
  logic [2:0]       funct3_E;
  logic             funct7_5_E;
  logic [1:0]       aluop_E;
  logic             branch_E;
  logic             memtoreg_E;
  logic             memwrite_E;
  logic             regwrite_E;
  logic             aluSrc_E;
  logic [REGW-1:0]  rd_W;
  logic             regwrite_W;
  logic [WIDTH-1:0] writeData;

  logic [WIDTH-1:0] alu_result_M;
  logic [WIDTH-1:0] write_data_M;
  logic [REGW-1:0]  rd_M;
  logic [2:0]       funct3_M;
  logic             memtoreg_M;
  logic             memwrite_M;
  logic             regwrite_M;
  logic [WIDTH-1:0] PC_M;
  logic             takeBranch;
  logic             flush;

  modport master (
    output PC_E, imm_data_E, rd1_E, rd2_E, rs1_E, rs2_E, rd_E, funct3_E, funct7_5_E,
           aluop_E, branch_E, memtoreg_E, memwrite_E, regwrite_E, aluSrc_E,
           rd_W, regwrite_W, writeData,
    input  alu_result_M, write_data_M, rd_M, funct3_M, memtoreg_M, memwrite_M,
           regwrite_M, PC_M, takeBranch, flush
  );

  modport slave (
    input  PC_E, imm_data_E, rd1_E, rd2_E, rs1_E, rs2_E, rd_E, funct3_E, funct7_5_E,
           aluop_E, branch_E, memtoreg_E, memwrite_E, regwrite_E, aluSrc_E,
           rd_W, regwrite_W, writeData,
    output alu_result_M, write_data_M, rd_M, funct3_M, memtoreg_M, memwrite_M,
           regwrite_M, PC_M, takeBranch, flush
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU decode/compute, branch resolution
// and the EX/MEM pipeline register with taken-branch squash of younger work.
module execute_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5
) (
  input logic            clk,
  input logic            reset,
  execute_stage_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  logic [WIDTH-1:0] alu_result_q, write_data_q, pc_target_q;
  logic [REGW-1:0]  rd_q;
  logic [2:0]       funct3_q;
  logic             memtoreg_q, memwrite_q, regwrite_q, take_branch_q;

  logic [WIDTH-1:0] fwd_a, fwd_b, alu_b, alu_y;
  alu_op_e          alu_op;
  logic             cond, taken;

  // Forwarding muxes; the younger M result wins over W, x0 never forwards.
  always_comb begin
    fwd_a = bus.rd1_E;
    if (regwrite_q && (rd_q != '0) && (rd_q == bus.rs1_E))
      fwd_a = alu_result_q;
    else if (bus.regwrite_W && (bus.rd_W != '0) && (bus.rd_W == bus.rs1_E))
      fwd_a = bus.writeData;

    fwd_b = bus.rd2_E;
    if (regwrite_q && (rd_q != '0) && (rd_q == bus.rs2_E))
      fwd_b = alu_result_q;
    else if (bus.regwrite_W && (bus.rd_W != '0) && (bus.rd_W == bus.rs2_E))
      fwd_b = bus.writeData;
  end

  assign alu_b = bus.aluSrc_E ? bus.imm_data_E : fwd_b;

  // ALU control decode; funct7_5 selects SUB only for R-type, SRA for both.
  always_comb begin
    alu_op = ALU_ADD;
    case (bus.aluop_E)
      2'b00: alu_op = ALU_ADD;
      2'b01: alu_op = ALU_SUB;
      default: begin
        case (bus.funct3_E)
          3'b000: alu_op = (bus.aluop_E == 2'b10 && bus.funct7_5_E) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = bus.funct7_5_E ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = fwd_a + alu_b;
      ALU_SUB:  alu_y = fwd_a - alu_b;
      ALU_SLL:  alu_y = fwd_a << alu_b[SHW-1:0];
      ALU_SLT:  alu_y = WIDTH'($signed(fwd_a) < $signed(alu_b));
      ALU_SLTU: alu_y = WIDTH'(fwd_a < alu_b);
      ALU_XOR:  alu_y = fwd_a ^ alu_b;
      ALU_SRL:  alu_y = fwd_a >> alu_b[SHW-1:0];
      ALU_SRA:  alu_y = WIDTH'($signed(fwd_a) >>> alu_b[SHW-1:0]);
      ALU_OR:   alu_y = fwd_a | alu_b;
      ALU_AND:  alu_y = fwd_a & alu_b;
      default:  alu_y = '0;
    endcase
  end

  // Branch compare always uses register operands, never the immediate.
  always_comb begin
    cond = 1'b0;
    case (bus.funct3_E)
      3'b000: cond = (fwd_a == fwd_b);
      3'b001: cond = (fwd_a != fwd_b);
      3'b100: cond = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101: cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110: cond = (fwd_a <  fwd_b);
      3'b111: cond = (fwd_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  assign taken = bus.branch_E && cond;

  // EX/MEM register; a taken branch in M kills the instruction now in EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_q  <= '0;
      write_data_q  <= '0;
      pc_target_q   <= '0;
      rd_q          <= '0;
      funct3_q      <= '0;
      memtoreg_q    <= 1'b0;
      memwrite_q    <= 1'b0;
      regwrite_q    <= 1'b0;
      take_branch_q <= 1'b0;
    end else begin
      alu_result_q  <= alu_y;
      write_data_q  <= fwd_b;
      pc_target_q   <= bus.PC_E + bus.imm_data_E;
      rd_q          <= bus.rd_E;
      funct3_q      <= bus.funct3_E;
      memtoreg_q    <= bus.memtoreg_E && !take_branch_q;
      memwrite_q    <= bus.memwrite_E && !take_branch_q;
      regwrite_q    <= bus.regwrite_E && !take_branch_q;
      take_branch_q <= taken && !take_branch_q;
    end
  end

  assign bus.alu_result_M = alu_result_q;
  assign bus.write_data_M = write_data_q;
  assign bus.rd_M         = rd_q;
  assign bus.funct3_M     = funct3_q;
  assign bus.memtoreg_M   = memtoreg_q;
  assign bus.memwrite_M   = memwrite_q;
  assign bus.regwrite_M   = regwrite_q;
  assign bus.PC_M         = pc_target_q;
  assign bus.takeBranch   = take_branch_q;
  assign bus.flush        = take_branch_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expected values.
module tb_execute_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  execute_stage_if #(.WIDTH(32), .REGW(5)) bus ();

  execute_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nop_in();
    bus.PC_E = '0; bus.imm_data_E = '0; bus.rd1_E = '0; bus.rd2_E = '0;
    bus.rs1_E = '0; bus.rs2_E = '0; bus.rd_E = '0;
    bus.funct3_E = '0; bus.funct7_5_E = 1'b0; bus.aluop_E = '0;
    bus.branch_E = 1'b0; bus.memtoreg_E = 1'b0; bus.memwrite_E = 1'b0;
    bus.regwrite_E = 1'b0; bus.aluSrc_E = 1'b0;
    bus.rd_W = '0; bus.regwrite_W = 1'b0; bus.writeData = '0;
  endtask

  // Apply current inputs across one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_r(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic f7);
    nop_in();
    bus.rs1_E = 5'd1; bus.rs2_E = 5'd2; bus.rd1_E = a; bus.rd2_E = b;
    bus.aluop_E = 2'b10; bus.funct3_E = f3; bus.funct7_5_E = f7;
    bus.regwrite_E = 1'b1; bus.rd_E = 5'd7;
  endtask

  task automatic branch_in(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    nop_in();
    bus.rs1_E = 5'd1; bus.rs2_E = 5'd2; bus.rd1_E = a; bus.rd2_E = b;
    bus.aluop_E = 2'b01; bus.funct3_E = f3; bus.branch_E = 1'b1;
  endtask

  initial begin
    // Reset with a taken-looking beq and regwrite asserted
    nop_in();
    reset = 1'b1;
    bus.regwrite_E = 1'b1; bus.branch_E = 1'b1; bus.rd_E = 5'd3;
    bus.PC_E = 32'h100; bus.imm_data_E = 32'h20; bus.rd1_E = 32'h5; bus.rd2_E = 32'h5;
    step(); step();
    check_eq("rst_alu",   bus.alu_result_M, 32'h0);
    check_eq("rst_pcm",   bus.PC_M, 32'h0);
    check_eq("rst_rdm",   32'(bus.rd_M), 32'h0);
    check_eq("rst_regw",  32'(bus.regwrite_M), 32'h0);
    check_eq("rst_take",  32'(bus.takeBranch), 32'h0);
    check_eq("rst_flush", 32'(bus.flush), 32'h0);
    reset = 1'b0;

    // R-type shifts and set-less-than
    alu_r(32'hFFFF_FFF0, 32'd3, 3'b101, 1'b1); step();
    check_eq("sra", bus.alu_result_M, 32'hFFFF_FFFE);
    check_eq("sra_rdm", 32'(bus.rd_M), 32'd7);
    check_eq("sra_regw", 32'(bus.regwrite_M), 32'd1);
    check_eq("sra_f3m", 32'(bus.funct3_M), 32'd5);
    alu_r(32'hFFFF_FFF0, 32'd3, 3'b101, 1'b0); step();
    check_eq("srl", bus.alu_result_M, 32'h1FFF_FFFE);
    alu_r(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0); step();
    check_eq("slt", bus.alu_result_M, 32'd1);
    alu_r(32'hFFFF_FFFF, 32'd1, 3'b011, 1'b0); step();
    check_eq("sltu", bus.alu_result_M, 32'd0);
    alu_r(32'd10, 32'd3, 3'b000, 1'b1); step();
    check_eq("sub", bus.alu_result_M, 32'd7);
    alu_r(32'd10, 32'd3, 3'b000, 1'b0); bus.aluop_E = 2'b11; step();
    check_eq("addi_f7", bus.alu_result_M, 32'd13);

    // Forwarding: x5=0x11 produced into M
    nop_in(); bus.rs1_E = 5'd1; bus.rd1_E = 32'h11; bus.regwrite_E = 1'b1; bus.rd_E = 5'd5;
    step();
    check_eq("prod_x5", bus.alu_result_M, 32'h11);
    // M and W both write x5: M must win
    nop_in(); bus.rs1_E = 5'd5; bus.rd1_E = 32'h99; bus.regwrite_E = 1'b1; bus.rd_E = 5'd0;
    bus.rd_W = 5'd5; bus.regwrite_W = 1'b1; bus.writeData = 32'h22;
    step();
    check_eq("fwd_m_prio", bus.alu_result_M, 32'h11);
    // Only W matches now
    nop_in(); bus.rs1_E = 5'd5; bus.rd1_E = 32'h99; bus.regwrite_E = 1'b1; bus.rd_E = 5'd0;
    bus.rd_W = 5'd5; bus.regwrite_W = 1'b1; bus.writeData = 32'h22;
    step();
    check_eq("fwd_w", bus.alu_result_M, 32'h22);
    // rd=0 in both M and W must never forward
    nop_in(); bus.rs1_E = 5'd0; bus.rd1_E = 32'h99;
    bus.rd_W = 5'd0; bus.regwrite_W = 1'b1; bus.writeData = 32'h22;
    step();
    check_eq("fwd_x0", bus.alu_result_M, 32'h99);

    // Store: base+imm, store data forwarded from W
    nop_in(); bus.rs1_E = 5'd1; bus.rd1_E = 32'h1000; bus.rs2_E = 5'd6; bus.rd2_E = 32'h0;
    bus.aluSrc_E = 1'b1; bus.imm_data_E = 32'd8; bus.memwrite_E = 1'b1;
    bus.rd_W = 5'd6; bus.regwrite_W = 1'b1; bus.writeData = 32'hDEAD_BEEF;
    step();
    check_eq("st_addr", bus.alu_result_M, 32'h1008);
    check_eq("st_data", bus.write_data_M, 32'hDEAD_BEEF);
    check_eq("st_memw", 32'(bus.memwrite_M), 32'd1);
    check_eq("st_regw", 32'(bus.regwrite_M), 32'd0);

    // Taken beq with a backward target
    branch_in(32'd7, 32'd7, 3'b000); bus.PC_E = 32'h40; bus.imm_data_E = 32'hFFFF_FFF0;
    step();
    check_eq("beq_take",  32'(bus.takeBranch), 32'd1);
    check_eq("beq_pcm",   bus.PC_M, 32'h30);
    check_eq("beq_flush", 32'(bus.flush), 32'd1);
    // Younger instruction in EX is squashed and cannot redirect
    branch_in(32'd1, 32'd1, 3'b000); bus.regwrite_E = 1'b1; bus.memwrite_E = 1'b1;
    bus.rd_E = 5'd4; bus.PC_E = 32'h44;
    step();
    check_eq("sq_regw",  32'(bus.regwrite_M), 32'd0);
    check_eq("sq_memw",  32'(bus.memwrite_M), 32'd0);
    check_eq("sq_take",  32'(bus.takeBranch), 32'd0);
    check_eq("sq_flush", 32'(bus.flush), 32'd0);

    // Not-taken and reserved conditions
    branch_in(32'd5, 32'd3, 3'b110); step();
    check_eq("bltu_nt", 32'(bus.takeBranch), 32'd0);
    branch_in(32'd5, 32'd5, 3'b010); step();
    check_eq("rsvd_nt", 32'(bus.takeBranch), 32'd0);
    branch_in(32'hFFFF_FFFF, 32'd1, 3'b111); step();
    check_eq("bgeu_t", 32'(bus.takeBranch), 32'd1);
    branch_in(32'd0, 32'd0, 3'b000); step();
    branch_in(32'hFFFF_FFFF, 32'd1, 3'b100); step();
    check_eq("blt_t", 32'(bus.takeBranch), 32'd1);

    // Mid-stream reset wins over a taken branch
    branch_in(32'd2, 32'd2, 3'b000); bus.PC_E = 32'h80; reset = 1'b1;
    step();
    check_eq("mrst_take", 32'(bus.takeBranch), 32'd0);
    check_eq("mrst_pcm",  bus.PC_M, 32'h0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline. Consumes the ID/EX register outputs and performs operand forwarding, ALU control decode, ALU operation and branch resolution.
- Registers its results into an internal EX/MEM pipeline register that feeds the memory stage.
- Drives the branch redirect (takeBranch, PC_M) back to the fetch mux, and drives flush to the IF/ID and ID/EX registers.

Parameters:
WIDTH, 32, datapath width.
REGW, 5, register-address width.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
PC_E  in  WIDTH  PC of instruction in EX
imm_data_E  in  WIDTH  sign-extended immediate
rd1_E, rd2_E  in  WIDTH  register-file read data
rs1_E, rs2_E, rd_E  in  REGW  source/destination register indices
funct3_E  in  3  funct3 field
funct7_5_E  in  1  funct7 bit 5
aluop_E  in  2  ALU class from control unit
branch_E, memtoreg_E, memwrite_E, regwrite_E, aluSrc_E  in  1  control bits
rd_W  in  REGW  writeback destination
regwrite_W  in  1  writeback enable
writeData  in  WIDTH  writeback data
alu_result_M  out  WIDTH  registered ALU result (memory address or value)
write_data_M  out  WIDTH  registered forwarded rs2 data (store data)
rd_M  out  REGW  registered destination
funct3_M  out  3  registered funct3 (load/store size)
memtoreg_M, memwrite_M, regwrite_M  out  1  registered control bits
PC_M  out  WIDTH  registered branch target
takeBranch  out  1  registered branch-taken
flush  out  1  squash younger instructions

Behaviour:
- Reset: all registered outputs are 0 on the first rising edge with reset=1, including takeBranch. The same applies to a reset asserted mid-stream; reset has priority over flush.
- Forwarding, operand A:
  - If regwrite_M && rd_M!=0 && rd_M==rs1_E, use alu_result_M.
  - Else if regwrite_W && rd_W!=0 && rd_W==rs1_E, use writeData.
  - Else use rd1_E.
  - The M source has priority over W.
- Forwarding, operand B: same priority rules using rs2_E and rd2_E, giving fwdB.
- Operands: the ALU B input is imm_data_E when aluSrc_E=1, else fwdB. write_data_M captures fwdB.
- Load-use: hazards are resolved upstream by a one-bubble stall. This block forwards alu_result_M unconditionally and never produces load data.
- ALU control by aluop_E:
  - 00: ADD.
  - 01: branch compare, result = A-B.
  - 10: R-type by funct3/funct7_5. 000 ADD (SUB if f7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if f7_5), 110 OR, 111 AND.
  - 11: I-type, same table except funct7_5 is honoured only for funct3=101; 000 is always ADD.
- Arithmetic rules: shifts use B[4:0]; SLT/SLTU yield 0 or 1 zero-extended; all arithmetic wraps modulo 2^WIDTH.
- Branch condition uses forwarded A vs fwdB (never the immediate), by funct3:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 are never taken.
  - taken_E = branch_E && condition.
- Branch target: PC_E + imm_data_E, registered into PC_M every non-reset cycle.
- EX/MEM register: latency 1, updates every cycle, no stall input.
- Squash when flush=1 at the edge: regwrite_M, memwrite_M, memtoreg_M and takeBranch capture 0. Data fields may capture anything.
- Redirect: flush = takeBranch (combinational from the register).
  - Branches resolve in M; the three younger instructions in IF, ID and EX are squashed.
  - Penalty is 3 cycles.
  - A branch in EX while an older taken branch is in M is squashed and never redirects.
- Simultaneous M and W match on the same register: M wins.
- Destination x0: rd=0 never forwards.

Test Plan:
- Reset: hold reset 2 cycles with regwrite_E=1, branch_E=1, and taken conditions → all outputs 0, flush=0.
- R-type: A=0xFFFFFFF0, B=3, aluop=10, funct3=101, f7_5=1 → next cycle alu_result_M=0xFFFFFFFE; with f7_5=0 → 0x1FFFFFFE. SLT -1 vs 1 → 1; SLTU → 0.
- Forward priority: rs1_E=5, previous instruction writes x5=0x11 (M), W writes x5=0x22 → A=0x11. With rd=0 on both → rd1_E used.
- Store: aluSrc=1, imm=8, rs2 forwarded from W=0xDEADBEEF → alu_result_M=base+8, write_data_M=0xDEADBEEF, memwrite_M=1.
- Branch: PC_E=0x40, imm=-16, beq with equal operands → next cycle takeBranch=1, PC_M=0x30, flush=1. The following EX instruction (regwrite_E=1) produces regwrite_M=0 and does not redirect even if its own branch condition holds.
- Not-taken and reserved: bltu 5 vs 3 → takeBranch=0; funct3=010 with branch_E=1 → takeBranch=0.
